// File: rtl/mem_arbiter.sv
// Time-shares one single-port 256x32 memory between an instruction-fetch port and a data port.
// Build option ARB_RR_EN: round-robin on simultaneous requests; otherwise fixed data-over-fetch priority.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [7:0]  if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [7:0]  d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, IF_ACC, D_ACC, RESP} state_t;

  state_t      state, next_state;
  logic        grant_if, grant_d;
  logic        owner_d_p0;
  logic [7:0]  addr_p0;
  logic        we_p0;
  logic [31:0] wdata_p0;
  logic        d_rd_p2;
  logic [31:0] if_rdata_q, d_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (grant_d)       next_state = D_ACC;
        else if (grant_if) next_state = IF_ACC;
      end
      IF_ACC, D_ACC: next_state = RESP;
      RESP:          next_state = IDLE;
      default:       next_state = IDLE;
    endcase
  end

`ifdef ARB_RR_EN
  logic last_d;

  always_comb begin
    grant_d  = 1'b0;
    grant_if = 1'b0;
    if (state == IDLE) begin
      if (if_req && d_req) begin
        grant_d  = !last_d;
        grant_if = last_d;
      end else begin
        grant_d  = d_req;
        grant_if = if_req;
      end
    end
  end

  // Pointer remembers the last winner; after reset fetch counts as last, so data wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  last_d <= 1'b0;
    else if (grant_d || grant_if) last_d <= grant_d;
  end
`else
  always_comb begin
    grant_d  = (state == IDLE) && d_req;
    grant_if = (state == IDLE) && if_req && !d_req;
  end
`endif

  // p0: request latched at grant
  always_ff @(posedge clk) begin
    if (grant_if || grant_d) begin
      addr_p0  <= grant_d ? d_addr : if_addr;
      we_p0    <= grant_d && d_we;
      wdata_p0 <= d_wdata;
    end
  end

  // p1: memory strobe; p2: response and read-data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_d_p0 <= 1'b0;
      if_gnt     <= 1'b0;
      d_gnt      <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_valid   <= 1'b0;
      d_valid    <= 1'b0;
      d_rd_p2    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if_gnt <= grant_if;
      d_gnt  <= grant_d;
      if (grant_if || grant_d) owner_d_p0 <= grant_d;
      mem_en <= (state == IF_ACC) || (state == D_ACC);
      mem_we <= (state == D_ACC) && we_p0;
      if ((state == IF_ACC) || (state == D_ACC)) mem_addr <= addr_p0;
      if (state == D_ACC) mem_wdata <= wdata_p0;
      if_valid <= (state == RESP) && !owner_d_p0;
      d_valid  <= (state == RESP) && owner_d_p0;
      d_rd_p2  <= (state == RESP) && owner_d_p0 && !we_p0;
      if (if_valid) if_rdata_q <= mem_rdata;
      if (d_rd_p2)  d_rdata_q  <= mem_rdata;
    end
  end

  // Memory data arrives in the valid cycle, so it is forwarded then and held afterwards.
  assign if_rdata = if_valid ? mem_rdata : if_rdata_q;
  assign d_rdata  = d_rd_p2  ? mem_rdata : d_rdata_q;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory model, shadow reference memory and arbitration model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [7:0]  if_addr = '0;
  logic        if_gnt, if_valid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [7:0]  d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt, d_valid;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic [31:0] exp_if_rdata = '0, exp_d_rdata = '0;
  int n_checks = 0, n_fail = 0, cyc = 0;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
      else                 mem_rdata <= mem[mem_addr];
    end
  end

  task automatic apply_reset;
    @(negedge clk);
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
  endtask

  task automatic do_access(input bit is_d, input bit we, input logic [7:0] addr, input logic [31:0] wdata);
    bit got;
    int n;
    logic [31:0] exp;
    @(negedge clk);
    if (is_d) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; end
    else begin if_req = 1'b1; if_addr = addr; end
    got = 0; n = 0;
    while (!got && n < 10) begin
      @(negedge clk);
      got = is_d ? (d_gnt === 1'b1) : (if_gnt === 1'b1);
      n++;
    end
    if_req = 1'b0; d_req = 1'b0;
    n_checks++;
    if (!got || n != 1 || (if_gnt === 1'b1 && d_gnt === 1'b1)) begin
      n_fail++;
      $display("FAIL access_gnt port_d=%0d addr=%h: waited %0d cycles if_gnt=%b d_gnt=%b, required own grant after 1 cycle",
               is_d, addr, n, if_gnt, d_gnt);
    end
    if (!got) return;
    @(negedge clk);
    n_checks++;
    if (mem_en !== 1'b1 || mem_addr !== addr || mem_we !== (is_d && we) ||
        (is_d && we && mem_wdata !== wdata) || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL access_mem port_d=%0d: en=%b addr=%h we=%b wdata=%h busy=%b, required en=1 addr=%h we=%b wdata=%h busy=1",
               is_d, mem_en, mem_addr, mem_we, mem_wdata, busy, addr, is_d && we, wdata);
    end
    @(negedge clk);
    if (is_d) begin
      if (!we) exp_d_rdata = ref_mem[addr];
    end else begin
      exp_if_rdata = ref_mem[addr];
    end
    exp = is_d ? exp_d_rdata : exp_if_rdata;
    n_checks++;
    if (if_valid !== !is_d || d_valid !== is_d || mem_en !== 1'b0 ||
        if_rdata !== exp_if_rdata || d_rdata !== exp_d_rdata) begin
      n_fail++;
      $display("FAIL access_resp port_d=%0d addr=%h: if_valid=%b d_valid=%b mem_en=%b if_rdata=%h d_rdata=%h, required valid on own port, mem_en=0, if_rdata=%h d_rdata=%h (own %h)",
               is_d, addr, if_valid, d_valid, mem_en, if_rdata, d_rdata, exp_if_rdata, exp_d_rdata, exp);
    end
    if (is_d && we) ref_mem[addr] = wdata;
  endtask

  task automatic test_reset;
    logic [110:0] snap;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    snap = {if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy};
    n_checks++;
    if (snap !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required all zero", snap);
    end
    // release with a request already pending: grant must follow the first edge
    rst_n = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h00;
    @(negedge clk);
    n_checks++;
    if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_arb: d_gnt=%b if_gnt=%b, required d_gnt=1 if_gnt=0", d_gnt, if_gnt);
    end
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    exp_d_rdata = ref_mem[0];
    n_checks++;
    if (d_valid !== 1'b1 || d_rdata !== exp_d_rdata) begin
      n_fail++;
      $display("FAIL reset_first_resp: d_valid=%b d_rdata=%h, required 1 and %h", d_valid, d_rdata, exp_d_rdata);
    end
  endtask

  task automatic test_fetch_only;
    mem[5] = 32'h00500093;
    ref_mem[5] = 32'h00500093;
    do_access(1'b0, 1'b0, 8'h05, '0);
    n_checks++;
    if (if_rdata !== 32'h00500093) begin
      n_fail++;
      $display("FAIL fetch_hold: if_rdata=%h, required 00500093", if_rdata);
    end
  endtask

  task automatic test_write_read;
    do_access(1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
    do_access(1'b1, 1'b0, 8'h10, '0);
    n_checks++;
    if (d_rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL write_read: d_rdata=%h, required deadbeef", d_rdata);
    end
  endtask

  task automatic test_reset_mid;
    logic [110:0] snap;
    logic [31:0]  wd;
    int n;
    bit got;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h33;
    got = 0; n = 0;
    while (!got && n < 10) begin @(negedge clk); got = (d_gnt === 1'b1); n++; end
    d_req = 1'b0;
    #1 rst_n = 1'b0;
    #1 snap = {if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy};
    n_checks++;
    if (!got || snap !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: granted=%0d outputs=%h, required grant then all zero", got, snap);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_if_rdata = '0; exp_d_rdata = '0;
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if (d_valid !== 1'b0 || mem_en !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_abort: d_valid=%b mem_en=%b busy=%b, required 0 0 0", d_valid, mem_en, busy);
      end
    end
    do_access(1'b1, 1'b0, 8'h33, '0);
    // aborted write must never reach memory
    wd = ~ref_mem[8'h44];
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h44; d_wdata = wd;
    got = 0; n = 0;
    while (!got && n < 10) begin @(negedge clk); got = (d_gnt === 1'b1); n++; end
    d_req = 1'b0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_if_rdata = '0; exp_d_rdata = '0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (!got || mem_en !== 1'b0 || d_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_write_abort: granted=%0d mem_en=%b d_valid=%b, required grant then mem_en=0 d_valid=0", got, mem_en, d_valid);
      end
    end
    do_access(1'b1, 1'b0, 8'h44, '0);
  endtask

  task automatic test_if_pulse;
    int n;
    bit got;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h21;
    got = 0; n = 0;
    while (!got && n < 10) begin @(negedge clk); got = (d_gnt === 1'b1); n++; end
    d_req = 1'b0;
    if_req = 1'b1; if_addr = 8'h77;
    @(negedge clk);
    if_req = 1'b0;
    n_checks++;
    if (!got || mem_en !== 1'b1 || mem_addr !== 8'h21) begin
      n_fail++;
      $display("FAIL if_pulse_data: granted=%0d mem_en=%b mem_addr=%h, required 1 and 21", got, mem_en, mem_addr);
    end
    exp_d_rdata = ref_mem[8'h21];
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if (if_gnt !== 1'b0 || if_valid !== 1'b0 || mem_en !== 1'b0) begin
        n_fail++;
        $display("FAIL if_pulse_ignored: if_gnt=%b if_valid=%b mem_en=%b, required all 0", if_gnt, if_valid, mem_en);
      end
    end
    n_checks++;
    if (d_rdata !== exp_d_rdata) begin
      n_fail++;
      $display("FAIL if_pulse_rdata: d_rdata=%h, required %h", d_rdata, exp_d_rdata);
    end
  endtask

  task automatic test_arbitration;
    logic [7:0] ia, da;
    bit last_d, exp_d, got;
    int n, prev;
    logic [31:0] exp;
    apply_reset;
    last_d = 1'b0;
    ia = 8'($urandom); da = 8'($urandom);
    if_req = 1'b1; if_addr = ia; d_req = 1'b1; d_we = 1'b0; d_addr = da;
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      got = 0; n = 0;
      while (!got && n < 10) begin @(negedge clk); got = (if_gnt === 1'b1) || (d_gnt === 1'b1); n++; end
`ifdef ARB_RR_EN
      exp_d = !last_d;
`else
      exp_d = 1'b1;
`endif
      last_d = exp_d;
      n_checks++;
      if (!got || d_gnt !== exp_d || if_gnt !== !exp_d || (prev >= 0 && cyc - prev != 3)) begin
        n_fail++;
        $display("FAIL arb_grant_%0d: d_gnt=%b if_gnt=%b spacing=%0d, required d_gnt=%b if_gnt=%b spacing=3",
                 k, d_gnt, if_gnt, (prev >= 0) ? cyc - prev : 3, exp_d, !exp_d);
      end
      if (!got) break;
      prev = cyc;
      if (k == 3) begin if_req = 1'b0; d_req = 1'b0; end
      @(negedge clk);
      @(negedge clk);
      exp = ref_mem[exp_d ? da : ia];
      n_checks++;
      if (d_valid !== exp_d || if_valid !== !exp_d || (exp_d ? d_rdata : if_rdata) !== exp) begin
        n_fail++;
        $display("FAIL arb_resp_%0d: d_valid=%b if_valid=%b rdata=%h, required d_valid=%b rdata=%h",
                 k, d_valid, if_valid, exp_d ? d_rdata : if_rdata, exp_d, exp);
      end
      if (exp_d) exp_d_rdata = exp; else exp_if_rdata = exp;
    end
  endtask

  task automatic test_random;
    bit is_d, we;
    for (int i = 0; i < 30; i++) begin
      is_d = 1'($urandom);
      we   = is_d && 1'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_access(is_d, we, 8'($urandom_range(0, 15)), $urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    test_reset;
    test_fetch_only;
    test_write_read;
    test_reset_mid;
    test_if_pulse;
    test_arbitration;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk (rising edge) and rst_n (low = reset, asserted asynchronously).
REQ-002 Port list, in order (name  direction  width  meaning):
 - clk  in  1  system clock
 - rst_n  in  1  async active-low reset
 - if_req  in  1  instruction fetch request (level)
 - if_addr  in  8  fetch word address
 - if_gnt  out  1  1-cycle pulse: fetch request accepted
 - if_valid  out  1  1-cycle pulse: if_rdata valid
 - if_rdata  out  32  fetched instruction word
 - d_req  in  1  data request (level)
 - d_we  in  1  1 = write, 0 = read
 - d_addr  in  8  data word address
 - d_wdata  in  32  write data
 - d_gnt  out  1  1-cycle pulse: data request accepted
 - d_valid  out  1  1-cycle pulse: read data valid / write done
 - d_rdata  out  32  read data
 - mem_en  out  1  memory access strobe
 - mem_we  out  1  memory write enable
 - mem_addr  out  8  memory word address
 - mem_wdata  out  32  memory write data
 - mem_rdata  in  32  memory read data, valid 1 cycle after mem_en with mem_we=0
 - busy  out  1  high whenever state is not IDLE

Function
REQ-003 The block SHALL time-share one single-port 256x32 memory between the fetch port and the data port.
REQ-004 FSM states SHALL be IDLE, IF_ACC, D_ACC and RESP.
REQ-005 IDLE SHALL arbitrate if_req and d_req in every cycle.
 - On a winner: pulse the matching gnt, latch its addr (and d_we/d_wdata for data), and go to IF_ACC or D_ACC.
 - With no request: stay in IDLE.
REQ-006 IF_ACC and D_ACC SHALL last exactly one cycle.
 - Drive mem_en=1 with the latched addr; for data also drive mem_we=latched d_we and mem_wdata.
 - Next state is RESP.
REQ-007 RESP SHALL last exactly one cycle.
 - Capture mem_rdata into if_rdata (fetch) or d_rdata (data read).
 - Pulse the owner's valid; for a data write, pulse d_valid and leave d_rdata unchanged.
 - Next state is IDLE.
REQ-008 Latency SHALL be fixed: gnt in cycle N, mem_en in N+1, valid in N+2; at most one access per 3 cycles.
REQ-009 Requesters SHALL hold req/addr/wdata stable until gnt; the block SHALL ignore requests outside IDLE.
REQ-010 A req deasserted before gnt SHALL cause no memory access and no valid pulse.
REQ-011 A req held high after gnt SHALL be treated as a new request in the next IDLE cycle.
REQ-012 Outside IF_ACC/D_ACC, mem_en and mem_we SHALL be 0; mem_addr and mem_wdata SHALL hold their last values.
REQ-013 if_rdata and d_rdata SHALL hold their last captured value until overwritten.
REQ-014 Addresses SHALL be passed through unmodified; 8-bit wrap is the memory's concern, with no range checking.
REQ-015 gnt, valid and mem_en SHALL be registered outputs (no combinational path from req).

Reset
REQ-016 On rst_n low, the block SHALL immediately force state=IDLE and all outputs to 0 (rdata buses = 32'h0).
REQ-017 Reset mid-operation SHALL abort the access with no valid pulse; a pending write SHALL NOT reach memory if reset asserts before its ACC cycle edge.
REQ-018 After rst_n rises, the first arbitration SHALL occur on the first clk edge.
REQ-019 With ARB_RR_EN defined, the round-robin pointer SHALL reset to last_grant=IF.

Configuration
REQ-020 Macro ARB_RR_EN SHALL select the arbitration policy for simultaneous requests; the single-request case is unaffected.
 - Defined: round-robin; on simultaneous if_req and d_req, grant the port not granted last; the pointer updates on every gnt.
 - Undefined: fixed priority, data over fetch; no pointer register exists.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
 - Fetch only: if_req=1, if_addr=8'h05, mem[5]=32'h00500093 -> if_gnt cycle N, mem_en N+1 with mem_addr=5, if_valid N+2 with if_rdata=32'h00500093.
 - Data write then read: d_we=1, d_addr=8'h10, d_wdata=32'hDEADBEEF -> mem_we=1 one cycle, d_valid pulse; then a read of 8'h10 -> d_rdata=32'hDEADBEEF.
 - Simultaneous if_req and d_req held for 4 accesses -> without ARB_RR_EN: D,D,D,D (fetch starved); with ARB_RR_EN: D,IF,D,IF.
 - rst_n low during D_ACC of a read -> no d_valid, busy=0 and all outputs 0 immediately; the next request completes normally.
 - if_req pulsed while in D_ACC and dropped before IDLE -> no if_gnt, no fetch access.
